knn_topk_stream: RTL and testbench



---
 rtl/knn_topk_stream.sv | 139 +++++++++++++
 tb/tb_knn_topk_stream.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/knn_topk_stream.sv
// knn_topk_stream: streaming 2-D KNN engine keeping a sorted top-K list of squared distances
module knn_topk_stream #(
  parameter int COORD_W = 16,
  parameter int K = 6,
  parameter int IDX_W = 8,
  localparam int DIST_W = 2*COORD_W+2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*COORD_W-1:0]  test_pt,
  input  logic                  pt_valid,
  input  logic [2*COORD_W-1:0]  pt_data,
  input  logic                  pt_last,
  output logic                  pt_ready,
  output logic                  busy,
  output logic                  done,
  output logic [K*DIST_W-1:0]   knn_dist,
  output logic [K*IDX_W-1:0]    knn_idx,
  output logic [4:0]            n_filled,
  output logic                  idx_ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic signed [COORD_W-1:0] tx, ty, px, py;
  logic signed [COORD_W:0] dx, dy;
  logic signed [DIST_W-1:0] sq_x, sq_y;
  logic [IDX_W-1:0] idx_cnt, s1_idx, s2_idx;
  logic [DIST_W-1:0] s2_dist;
  logic s1_v, s2_v, wrapped, accept;
  logic [DIST_W-1:0] slot_d [K];
  logic [IDX_W-1:0] slot_i [K];
  logic [DIST_W-1:0] nd [K];
  logic [IDX_W-1:0] ni [K];
  logic [K-1:0] le, prev;
  assign px = pt_data[2*COORD_W-1:COORD_W];
  assign py = pt_data[COORD_W-1:0];
  assign accept = pt_valid & pt_ready & ~start;
  assign sq_x = DIST_W'(dx) * DIST_W'(dx);
  assign sq_y = DIST_W'(dy) * DIST_W'(dy);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pt_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      tx <= '0;
      ty <= '0;
      idx_cnt <= '0;
      wrapped <= 1'b0;
      idx_ovf <= 1'b0;
    end else if (start) begin
      state <= RUN;
      pt_ready <= 1'b1;
      busy <= 1'b1;
      done <= 1'b0;
      {tx, ty} <= test_pt;
      idx_cnt <= '0;
      wrapped <= 1'b0;
      idx_ovf <= 1'b0;
    end else begin
      // overflow flags only once an index value is handed out a second time
      if (accept) begin
        idx_cnt <= idx_cnt + 1'b1;
        wrapped <= wrapped | (&idx_cnt);
        idx_ovf <= idx_ovf | wrapped;
      end
      case (state)
        RUN: if (accept && pt_last) begin
          state <= DRAIN;
          pt_ready <= 1'b0;
        end
        DRAIN: if (!s1_v) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: ;
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      dx <= '0;
      dy <= '0;
      s1_idx <= '0;
      s2_idx <= '0;
      s2_dist <= '0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v & ~start;
      dx <= (COORD_W+1)'(px) - (COORD_W+1)'(tx);
      dy <= (COORD_W+1)'(py) - (COORD_W+1)'(ty);
      s1_idx <= idx_cnt;
      s2_dist <= sq_x + sq_y;
      s2_idx <= s1_idx;
    end
  // empty slots hold all-ones, which exceeds any reachable distance, so they never count in le
  always_comb begin
    for (int i = 0; i < K; i++) le[i] = slot_d[i] <= s2_dist;
    prev = (le << 1) | K'(1);
    for (int i = 0; i < K; i++) begin
      nd[i] = le[i] ? slot_d[i] : s2_dist;
      ni[i] = le[i] ? slot_i[i] : s2_idx;
    end
    for (int i = 1; i < K; i++)
      if (!le[i] && !prev[i]) begin
        nd[i] = slot_d[i-1];
        ni[i] = slot_i[i-1];
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < K; i++) begin
        slot_d[i] <= '1;
        slot_i[i] <= '1;
      end
      n_filled <= '0;
    end else if (start) begin
      for (int i = 0; i < K; i++) begin
        slot_d[i] <= '1;
        slot_i[i] <= '1;
      end
      n_filled <= '0;
    end else if (s2_v) begin
      slot_d <= nd;
      slot_i <= ni;
      if (n_filled < 5'(K)) n_filled <= n_filled + 5'd1;
    end
  for (genvar g = 0; g < K; g++) begin : g_out
    assign knn_dist[g*DIST_W +: DIST_W] = slot_d[g];
    assign knn_idx[g*IDX_W +: IDX_W] = slot_i[g];
  end
endmodule

// File: tb/tb_knn_topk_stream.sv
// tb_knn_topk_stream: directed scoreboard bench for knn_topk_stream (K=6, COORD_W=16, IDX_W=4)
module tb_knn_topk_stream;
  localparam int CW = 16, K = 6, IW = 4, DW = 2*CW+2;
  logic clk = 0, rst = 1, start = 0, pt_valid = 0, pt_last = 0;
  logic [2*CW-1:0] test_pt = '0, pt_data = '0;
  logic pt_ready, busy, done, idx_ovf;
  logic [K*DW-1:0] knn_dist;
  logic [K*IW-1:0] knn_idx;
  logic [4:0] n_filled;
  logic [K*DW-1:0] ones_d = '1;
  logic [K*IW-1:0] ones_i = '1;
  typedef struct {
    logic [K*DW-1:0] d;
    logic [K*IW-1:0] i;
    logic [4:0] n;
    logic ovf;
  } exp_t;
  exp_t q[$];
  int sx[$], sy[$], mx[$], my[$];
  int tx, ty, saved;
  int compared = 0, mismatched = 0, done_cnt = 0, exp_done = 0;

  knn_topk_stream #(.COORD_W(CW), .K(K), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .test_pt(test_pt),
    .pt_valid(pt_valid), .pt_data(pt_data), .pt_last(pt_last), .pt_ready(pt_ready),
    .busy(busy), .done(done), .knn_dist(knn_dist), .knn_idx(knn_idx),
    .n_filled(n_filled), .idx_ovf(idx_ovf)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*CW-1:0] pk(input int x, input int y);
    return {x[CW-1:0], y[CW-1:0]};
  endfunction

  // rank-based reference: stable order by (distance, arrival)
  function automatic exp_t model();
    exp_t e;
    longint d[$];
    int n, rank;
    n = mx.size();
    for (int j = 0; j < n; j++) begin
      longint ex, ey;
      ex = mx[j] - tx;
      ey = my[j] - ty;
      d.push_back(ex*ex + ey*ey);
    end
    e.d = '1;
    e.i = '1;
    for (int j = 0; j < n; j++) begin
      rank = 0;
      for (int i = 0; i < n; i++) if (d[i] < d[j] || (d[i] == d[j] && i < j)) rank++;
      if (rank < K) begin
        e.d[rank*DW +: DW] = DW'(d[j]);
        e.i[rank*IW +: IW] = IW'(j);
      end
    end
    e.n = 5'(n < K ? n : K);
    e.ovf = n > (1 << IW);
    return e;
  endfunction

  task automatic push_exp();
    q.push_back(model());
    exp_done++;
  endtask

  task automatic do_start(input int x, input int y);
    @(negedge clk);
    tx = x;
    ty = y;
    test_pt = pk(x, y);
    start = 1;
    mx.delete();
    my.delete();
    @(negedge clk);
    start = 0;
    pt_valid = 0;
    check("busy_rise", busy, 1);
    check("ready_rise", pt_ready, 1);
  endtask

  task automatic feed(input bit last, input bit rnd);
    int k = 0;
    bit rdy_ok = 1;
    while (k < sx.size()) begin
      @(negedge clk);
      rdy_ok &= pt_ready;
      pt_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pt_last = 0;
      if (pt_valid) begin
        pt_data = pk(sx[k], sy[k]);
        pt_last = last && (k == sx.size() - 1);
        mx.push_back(sx[k]);
        my.push_back(sy[k]);
        k++;
      end
    end
    @(posedge clk);
    #1;
    pt_valid = 0;
    pt_last = 0;
    check("ready_held", rdy_ok, 1);
  endtask

  task automatic wait_done();
    int c = 0;
    exp_t e;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 20);
    check("done_latency", c, 3);
    check("busy_at_done", busy, 0);
    if (q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = q.pop_front();
    check("knn_dist", knn_dist, e.d);
    check("knn_idx", knn_idx, e.i);
    check("n_filled", n_filled, e.n);
    check("idx_ovf", idx_ovf, e.ovf);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_dist", knn_dist, ones_d);
    check("rst_idx", knn_idx, ones_i);
    check("rst_nfill", n_filled, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", pt_ready, 0);
    check("rst_ovf", idx_ovf, 0);
    rst = 0;

    do_start(0, 0);
    sx = '{3, 1, 0, 2, 10, 0, 6, 1};
    sy = '{4, 1, 5, 2, 0, 1, 8, 0};
    feed(1, 0);
    push_exp();
    wait_done();
    check("t1_slot0_dist", knn_dist[DW-1:0], 34'd1);
    check("t1_slot0_idx", knn_idx[IW-1:0], 4'd5);

    do_start(0, 0);
    sx = '{-2, 0, 5};
    sy = '{0, -1, 5};
    feed(1, 0);
    push_exp();
    wait_done();
    check("t2_slot3_empty", knn_dist[3*DW +: DW], 34'h3_FFFF_FFFF);

    do_start(-32768, -32768);
    sx = '{32767};
    sy = '{32767};
    feed(1, 0);
    push_exp();
    wait_done();
    check("extreme_dist", knn_dist[DW-1:0], 34'd8589672450);

    do_start(0, 0);
    sx = '{1, 2, 3, 4};
    sy = '{1, 2, 3, 4};
    feed(0, 0);
    pt_valid = 1;
    pt_data = pk(9, 9);
    do_start(1, 1);
    sx = '{4, 1};
    sy = '{5, 2};
    feed(1, 0);
    push_exp();
    wait_done();

    do_start(3, -2);
    sx.delete();
    sy.delete();
    for (int i = 0; i < 20; i++) begin
      sx.push_back(int'($urandom_range(0, 40)) - 20);
      sy.push_back(int'($urandom_range(0, 40)) - 20);
    end
    feed(1, 1);
    push_exp();
    wait_done();

    do_start(0, 0);
    sx = '{2, 1};
    sy = '{2, 3};
    feed(1, 0);
    #2 rst = 1;
    #1;
    check("drain_rst_dist", knn_dist, ones_d);
    check("drain_rst_nfill", n_filled, 0);
    check("drain_rst_busy", busy, 0);
    check("drain_rst_done", done, 0);
    saved = done_cnt;
    @(negedge clk);
    rst = 0;
    repeat (6) @(negedge clk);
    check("no_done_after_rst", done_cnt, saved);

    do_start(0, 0);
    sx = '{3, 1, 0, 2, 10, 0, 6, 1};
    sy = '{4, 1, 5, 2, 0, 1, 8, 0};
    feed(1, 0);
    push_exp();
    wait_done();

    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, exp_done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
